// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, scan-code prefixes and
// the odd-parity check used on every received frame.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  // True when data byte plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 clock conditioning: multi-stage synchroniser, run-length de-glitch
// filter (output starts high, the idle level of the bus) and a registered
// one-cycle pulse on every falling edge of the filtered clock.
module ps2_edge_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic raw,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   filt_reg;
  logic [CW-1:0]          run_reg;
  logic                   fall_reg;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign fall     = fall_reg;

  // Synchronise the pin, then only follow it after FILTER_LEN equal samples.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '1;
      filt_reg <= 1'b1;
      run_reg  <= '0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      fall_reg <= 1'b0;
      if (sync_out == filt_reg) begin
        run_reg <= '0;
      end else if (run_reg == RUN_LAST) begin
        filt_reg <= sync_out;
        run_reg  <= '0;
        fall_reg <= ~sync_out;
      end else begin
        run_reg <= run_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_module.sv
// PS/2 device-to-host receiver: de-glitched clock, 11-bit frame deserialiser
// with start/parity/stop checks and an inter-edge timeout. Good bytes leave
// as a one-cycle code_valid_o strobe; any frame fault as frame_err_o.
// Optional build macro PS2_BREAK_FILTER_EN: E0/F0 prefixes are absorbed and
// reported on code_ext_o/code_break_o alongside the following byte.
module ps2_rx_module #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       code_valid_o,
  output logic       code_ext_o,
  output logic       code_break_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  import ps2_pkg::*;

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic                   clk_fall;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   data_bit;

  ps2_state_t state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] tmo_reg;
  logic          busy_reg;
  logic [7:0]    code_reg;
  logic          valid_reg;
  logic          err_reg;

  logic timeout_hit;
  logic take;
  logic bad_start;
  logic stop_seen;
  logic stop_ok;
  logic byte_good;
  logic err_now;

  ps2_edge_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk  (CLK),
    .srst (RST),
    .raw  (ps2_clk_i),
    .fall (clk_fall)
  );

  // Data line is only synchronised; it is sampled in the filtered-clock fall cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_sync_reg <= '1;
    end else begin
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  assign data_bit = data_sync_reg[SYNC_STAGES-1];

  // Frame events for this cycle; a timeout swallows a coincident edge.
  always_comb begin
    timeout_hit = (state_reg != IDLE) && (tmo_reg == TMO_LAST);
    take        = clk_fall && !timeout_hit;
    bad_start   = take && (state_reg == IDLE) && data_bit;
    stop_seen   = take && (state_reg == STOP);
    stop_ok     = data_bit && odd_parity_ok(shift_reg, parity_reg);
    byte_good   = stop_seen && stop_ok;
    err_now     = timeout_hit || bad_start || (stop_seen && !stop_ok);
  end

  // Frame FSM, bit counter and inter-edge timeout counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tmo_reg     <= '0;
      busy_reg    <= 1'b0;
    end else if (timeout_hit) begin
      state_reg <= IDLE;
      tmo_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      if ((state_reg == IDLE) || clk_fall) begin
        tmo_reg <= '0;
      end else begin
        tmo_reg <= tmo_reg + TW'(1);
      end
      if (clk_fall) begin
        case (state_reg)
          IDLE: begin
            if (!data_bit) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
              busy_reg    <= 1'b1;
            end
          end
          DATA: begin
            shift_reg[bit_cnt_reg] <= data_bit;
            bit_cnt_reg            <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end
          end
          PARITY: begin
            parity_reg <= data_bit;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic pend_ext_reg;
  logic pend_break_reg;
  logic ext_reg;
  logic break_reg;

  // Output strobes; prefixes are held pending and attached to the next real byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      code_reg       <= '0;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
      pend_ext_reg   <= 1'b0;
      pend_break_reg <= 1'b0;
      ext_reg        <= 1'b0;
      break_reg      <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= err_now;
      if (err_now) begin
        pend_ext_reg   <= 1'b0;
        pend_break_reg <= 1'b0;
      end else if (byte_good) begin
        if (shift_reg == PS2_EXT_PREFIX) begin
          pend_ext_reg <= 1'b1;
        end else if (shift_reg == PS2_BREAK_PREFIX) begin
          pend_break_reg <= 1'b1;
        end else begin
          code_reg       <= shift_reg;
          valid_reg      <= 1'b1;
          ext_reg        <= pend_ext_reg;
          break_reg      <= pend_break_reg;
          pend_ext_reg   <= 1'b0;
          pend_break_reg <= 1'b0;
        end
      end
    end
  end

  assign code_ext_o   = ext_reg;
  assign code_break_o = break_reg;
`else
  // Output strobes; every good byte, prefixes included, is passed on raw.
  always_ff @(posedge CLK) begin
    if (RST) begin
      code_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      valid_reg <= byte_good;
      err_reg   <= err_now;
      if (byte_good) begin
        code_reg <= shift_reg;
      end
    end
  end

  assign code_ext_o   = 1'b0;
  assign code_break_o = 1'b0;
`endif

  assign code_o       = code_reg;
  assign code_valid_o = valid_reg;
  assign frame_err_o  = err_reg;
  assign busy_o       = busy_reg;

endmodule

// File: tb/tb_ps2_rx_module.sv
// Self-checking bench for ps2_rx_module. A frame-level model (good byte or
// faulty frame, plus prefix bookkeeping when PS2_BREAK_FILTER_EN is defined)
// predicts the strobes; a monitor records what the DUT actually emits.
module tb_ps2_rx_module;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TMO  = 10000;
  localparam int HALF = 30;              // PS/2 half period in CLK cycles
  localparam int LAT  = SYNC + FILT + 1; // pin fall -> strobe visible

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code_o;
  logic       code_valid_o, code_ext_o, code_break_o, frame_err_o, busy_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int fall_cyc = 0;

  ps2_rx_module #(
    .SYNC_STAGES (SYNC),
    .FILTER_LEN  (FILT),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .code_ext_o   (code_ext_o),
    .code_break_o (code_break_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: what the DUT emitted.
  logic [7:0] got_code_q[$];
  logic       got_ext_q[$];
  logic       got_brk_q[$];
  int got_err_n = 0;
  int overlap_n = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;

  always @(negedge clk) begin
    if (code_valid_o) begin
      got_code_q.push_back(code_o);
      got_ext_q.push_back(code_ext_o);
      got_brk_q.push_back(code_break_o);
      last_valid_cyc = cyc;
    end
    if (frame_err_o) begin
      got_err_n++;
      last_err_cyc = cyc;
    end
    if (code_valid_o && frame_err_o) overlap_n++;
  end

  // Reference model: frame-level expectations.
  logic [7:0] exp_code_q[$];
  logic       exp_ext_q[$];
  logic       exp_brk_q[$];
  int         exp_err_n = 0;
  logic [7:0] exp_held = 8'h00;
  logic       pend_ext_m = 1'b0;
  logic       pend_brk_m = 1'b0;

  task automatic model_good(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
    if (b == 8'hE0) pend_ext_m = 1'b1;
    else if (b == 8'hF0) pend_brk_m = 1'b1;
    else begin
      exp_code_q.push_back(b);
      exp_ext_q.push_back(pend_ext_m);
      exp_brk_q.push_back(pend_brk_m);
      exp_held = b;
      pend_ext_m = 1'b0;
      pend_brk_m = 1'b0;
    end
`else
    exp_code_q.push_back(b);
    exp_ext_q.push_back(1'b0);
    exp_brk_q.push_back(1'b0);
    exp_held = b;
`endif
  endtask

  task automatic model_err();
    exp_err_n++;
    pend_ext_m = 1'b0;
    pend_brk_m = 1'b0;
  endtask

  task automatic clear_logs();
    got_code_q.delete(); got_ext_q.delete(); got_brk_q.delete();
    exp_code_q.delete(); exp_ext_q.delete(); exp_brk_q.delete();
    exp_err_n = 0;
  endtask

  // Stimulus: a PS/2 device drives data while its clock is high.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ par_flip);
    drive_bit(stop_b);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(5);
    n_checks++;
    if ({code_o, code_valid_o, code_ext_o, code_break_o, frame_err_o, busy_o} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b%b required 00/00000", code_o,
               code_valid_o, code_ext_o, code_break_o, frame_err_o, busy_o);
    end
    rst = 1'b0;
    exp_held = 8'h00;
    pend_ext_m = 1'b0;
    pend_brk_m = 1'b0;
    wait_cyc(10);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b required 0", busy_o);
    end
  endtask

  task automatic test_basic();
    int err_base;
    clear_logs();
    err_base = got_err_n;
    drive_bit(1'b0);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_mid: got %b required 1", busy_o);
    end
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h1C >> i));
    drive_bit(~^8'h1C);
    drive_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    model_good(8'h1C);
    n_checks++;
    if (got_code_q.size() != 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d strobes required 1", got_code_q.size());
    end else begin
      n_checks++;
      if ({got_code_q[0], got_ext_q[0], got_brk_q[0]} !== {8'h1C, 2'b00}) begin
        n_fail++;
        $display("FAIL basic_code: got %h ext %b brk %b required 1c 0 0",
                 got_code_q[0], got_ext_q[0], got_brk_q[0]);
      end
      n_checks++;
      if (last_valid_cyc - fall_cyc != LAT) begin
        n_fail++;
        $display("FAIL basic_latency: got %0d cycles required %0d", last_valid_cyc - fall_cyc, LAT);
      end
    end
    n_checks++;
    if (busy_o !== 1'b0 || got_err_n != err_base) begin
      n_fail++;
      $display("FAIL basic_after: busy %b errors %0d required busy 0 errors 0", busy_o, got_err_n - err_base);
    end
  endtask

  task automatic test_parity_err();
    int err_base;
    clear_logs();
    err_base = got_err_n;
    send_frame(8'h5A, 1'b1, 1'b1);
    model_err();
    n_checks++;
    if (got_err_n - err_base != exp_err_n || got_code_q.size() != 0) begin
      n_fail++;
      $display("FAIL parity_err: got %0d errors %0d strobes required %0d errors 0 strobes",
               got_err_n - err_base, got_code_q.size(), exp_err_n);
    end
    n_checks++;
    if (last_err_cyc - fall_cyc != LAT) begin
      n_fail++;
      $display("FAIL parity_err_latency: got %0d required %0d", last_err_cyc - fall_cyc, LAT);
    end
    n_checks++;
    if (code_o !== exp_held) begin
      n_fail++;
      $display("FAIL parity_code_held: got %h required %h", code_o, exp_held);
    end
  endtask

  task automatic test_glitch();
    int err_base;
    logic busy_seen;
    clear_logs();
    err_base = got_err_n;
    busy_seen = 1'b0;
    ps2_data = 1'b1;
    for (int len = FILT - 2; len < FILT; len++) begin
      ps2_clk = 1'b0;
      wait_cyc(len);
      ps2_clk = 1'b1;
      for (int k = 0; k < 20; k++) begin
        wait_cyc(1);
        if (busy_o) busy_seen = 1'b1;
      end
    end
    n_checks++;
    if (busy_seen !== 1'b0 || got_err_n != err_base || got_code_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_ignored: busy %b errors %0d strobes %0d required 0 0 0",
               busy_seen, got_err_n - err_base, got_code_q.size());
    end
    // A low pulse of exactly FILTER_LEN cycles is a real edge; data high = bad start.
    ps2_clk = 1'b0;
    wait_cyc(FILT);
    ps2_clk = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_cyc(1);
      if (busy_o) busy_seen = 1'b1;
    end
    model_err();
    n_checks++;
    if (got_err_n - err_base != exp_err_n || got_code_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_start: got %0d errors %0d strobes required %0d errors 0 strobes",
               got_err_n - err_base, got_code_q.size(), exp_err_n);
    end
    n_checks++;
    if (busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_start_busy: got %b required 0", busy_seen);
    end
  endtask

  task automatic test_timeout();
    int err_base;
    logic [7:0] b;
    clear_logs();
    err_base = got_err_n;
    b = 8'($urandom);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    wait_cyc(12000);
    model_err();
    n_checks++;
    if (got_err_n - err_base != exp_err_n || got_code_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_err: got %0d errors %0d strobes required %0d errors 0 strobes",
               got_err_n - err_base, got_code_q.size(), exp_err_n);
    end
    // Counter clears when the last edge is taken, climbs to TMO-1, then the error registers.
    n_checks++;
    if (last_err_cyc - fall_cyc != LAT + TMO) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d required %0d", last_err_cyc - fall_cyc, LAT + TMO);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_busy: got %b required 0", busy_o);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    model_good(8'h1C);
    n_checks++;
    if (got_code_q.size() != 1 || got_err_n - err_base != exp_err_n) begin
      n_fail++;
      $display("FAIL timeout_recover_count: got %0d strobes %0d errors required 1 and %0d",
               got_code_q.size(), got_err_n - err_base, exp_err_n);
    end else begin
      n_checks++;
      if (got_code_q[0] !== 8'h1C) begin
        n_fail++;
        $display("FAIL timeout_recover_code: got %h required 1c", got_code_q[0]);
      end
    end
  endtask

  task automatic test_prefix();
    int err_base;
    logic [7:0] seq [4];
    clear_logs();
    err_base = got_err_n;
    seq[0] = 8'hE0; seq[1] = 8'hF0; seq[2] = 8'h75; seq[3] = 8'h75;
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 1'b0, 1'b1);
      model_good(seq[i]);
    end
    n_checks++;
    if (got_code_q.size() != exp_code_q.size()) begin
      n_fail++;
      $display("FAIL prefix_count: got %0d strobes required %0d", got_code_q.size(), exp_code_q.size());
    end
    for (int i = 0; i < got_code_q.size() && i < exp_code_q.size(); i++) begin
      n_checks++;
      if ({got_code_q[i], got_ext_q[i], got_brk_q[i]} !== {exp_code_q[i], exp_ext_q[i], exp_brk_q[i]}) begin
        n_fail++;
        $display("FAIL prefix_strobe%0d: got %h ext %b brk %b required %h ext %b brk %b", i,
                 got_code_q[i], got_ext_q[i], got_brk_q[i], exp_code_q[i], exp_ext_q[i], exp_brk_q[i]);
      end
    end
    n_checks++;
    if (got_err_n != err_base) begin
      n_fail++;
      $display("FAIL prefix_errors: got %0d required 0", got_err_n - err_base);
    end
  endtask

  task automatic test_random();
    int err_base;
    logic [7:0] b;
    int kind;
    int pick;
    clear_logs();
    err_base = got_err_n;
    for (int n = 0; n < 24; n++) begin
      pick = int'($urandom_range(0, 7));
      b = (pick == 0) ? 8'hE0 : (pick == 1) ? 8'hF0 : 8'($urandom);
      kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        send_frame(b, 1'b1, 1'b1);
        model_err();
      end else if (kind == 1) begin
        send_frame(b, 1'b0, 1'b0);
        model_err();
      end else begin
        send_frame(b, 1'b0, 1'b1);
        model_good(b);
      end
      $display("random frame %0d: byte %h kind %0d strobes %0d errors %0d", n, b, kind,
               got_code_q.size(), got_err_n - err_base);
    end
    n_checks++;
    if (got_code_q.size() != exp_code_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d strobes required %0d", got_code_q.size(), exp_code_q.size());
    end
    for (int i = 0; i < got_code_q.size() && i < exp_code_q.size(); i++) begin
      n_checks++;
      if ({got_code_q[i], got_ext_q[i], got_brk_q[i]} !== {exp_code_q[i], exp_ext_q[i], exp_brk_q[i]}) begin
        n_fail++;
        $display("FAIL random_strobe%0d: got %h ext %b brk %b required %h ext %b brk %b", i,
                 got_code_q[i], got_ext_q[i], got_brk_q[i], exp_code_q[i], exp_ext_q[i], exp_brk_q[i]);
      end
    end
    n_checks++;
    if (got_err_n - err_base != exp_err_n) begin
      n_fail++;
      $display("FAIL random_errors: got %0d required %0d", got_err_n - err_base, exp_err_n);
    end
    n_checks++;
    if (code_o !== exp_held) begin
      n_fail++;
      $display("FAIL random_code_held: got %h required %h", code_o, exp_held);
    end
  endtask

  task automatic test_reset_midframe();
    int err_base;
    clear_logs();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom));
    ps2_data = 1'($urandom);
    wait_cyc(HALF / 4);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy: got %b required 1", busy_o);
    end
    rst = 1'b1;
    wait_cyc(1);
    n_checks++;
    if ({code_o, code_valid_o, code_ext_o, code_break_o, frame_err_o, busy_o} !== 13'h0) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: got %h/%b%b%b%b%b required 00/00000", code_o,
               code_valid_o, code_ext_o, code_break_o, frame_err_o, busy_o);
    end
    rst = 1'b0;
    ps2_data = 1'b1;
    exp_held = 8'h00;
    pend_ext_m = 1'b0;
    pend_brk_m = 1'b0;
    wait_cyc(3 * HALF);
    got_code_q.delete(); got_ext_q.delete(); got_brk_q.delete();
    err_base = got_err_n;
    send_frame(8'h29, 1'b0, 1'b1);
    model_good(8'h29);
    n_checks++;
    if (got_code_q.size() != 1 || got_err_n != err_base) begin
      n_fail++;
      $display("FAIL midframe_recover_count: got %0d strobes %0d errors required 1 and 0",
               got_code_q.size(), got_err_n - err_base);
    end
    n_checks++;
    if (code_o !== exp_held) begin
      n_fail++;
      $display("FAIL midframe_recover_code: got %h required %h", code_o, exp_held);
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (overlap_n != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: got %0d cycles with both strobes required 0", overlap_n);
    end
  endtask

  initial begin
    test_reset();
    $display("test_reset done: checks %0d failures %0d", n_checks, n_fail);
    test_basic();
    $display("test_basic done: checks %0d failures %0d", n_checks, n_fail);
    test_parity_err();
    $display("test_parity_err done: checks %0d failures %0d", n_checks, n_fail);
    test_glitch();
    $display("test_glitch done: checks %0d failures %0d", n_checks, n_fail);
    test_timeout();
    $display("test_timeout done: checks %0d failures %0d", n_checks, n_fail);
    test_prefix();
    $display("test_prefix done: checks %0d failures %0d", n_checks, n_fail);
    test_random();
    $display("test_random done: checks %0d failures %0d", n_checks, n_fail);
    test_reset_midframe();
    $display("test_reset_midframe done: checks %0d failures %0d", n_checks, n_fail);
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
